hazard_ctrl_unit: RTL and testbench
===================================

Name: hazard_ctrl_unit

Overview:
Pipeline hazard controller for the five-stage RV32I core (F/D/E/M/W).
- Generates the execute-stage operand forwarding selects.
- Detects load-use RAW hazards and requests a stall plus bubble.
- Detects branch mispredictions and flushes the wrong-path instructions in Decode and Execute.
- All control outputs are purely combinational. The clock and reset serve only the optional performance counters.

Parameters:
CNT_W, 32, width of each optional performance counter.

Ports:
CLK  in  1  system clock
RST_N  in  1  reset, asynchronous, active-low
RS1_D  in  5  rs1 index of the instruction in Decode
RS2_D  in  5  rs2 index of the instruction in Decode
RD_E  in  5  rd index of the instruction in Execute
Result_Src_Sel_E  in  2  result source select of Execute; RESULT_ALU=2'h0, RESULT_MEM=2'h1 (load), other codes are non-load
RS1_E  in  5  rs1 index in Execute
RS2_E  in  5  rs2 index in Execute
RD_M  in  5  rd index in Memory
RD_W  in  5  rd index in Writeback
REG_W_En_M  in  1  Memory-stage instruction writes the register file
REG_W_En_W  in  1  Writeback-stage instruction writes the register file
Branch_Taken_E  in  1  actual branch outcome resolved in Execute
Predict_Taken_E  in  1  predicted outcome carried with the Execute instruction
FWD_SrcA  out  2  ALU operand A forward select
FWD_SrcB  out  2  ALU operand B forward select
Stall_En  out  1  hold the F/D pipeline register (stall Decode)
Flush_D  out  1  clear the F/D register to a NOP
Flush_E  out  1  clear the D/E register to a NOP
PC_En  out  1  PC update enable

Behaviour:
Forward select encodings (definitions package): FWD_NONE=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.

FWD_SrcA, evaluated in priority order:
- FWD_MEM when REG_W_En_M=1, RD_M==RS1_E and RS1_E!=0.
- Otherwise FWD_WB when REG_W_En_W=1, RD_W==RS1_E and RS1_E!=0.
- Otherwise FWD_NONE.
- Memory-stage forwarding has priority because it holds the younger value.

FWD_SrcB: identical rule using RS2_E.

Register x0 is never forwarded. A matching index with the corresponding write enable low produces FWD_NONE.

Definitions:
- load_use = (Result_Src_Sel_E==RESULT_MEM) && (RD_E!=0) && (RD_E==RS1_D || RD_E==RS2_D).
- mispredict = Branch_Taken_E != Predict_Taken_E.

Control outputs:
- Stall_En = load_use && !mispredict. On a mispredict the Decode instruction is wrong-path, so no stall is needed.
- PC_En = !Stall_En.
- Flush_D = mispredict.
- Flush_E = mispredict || load_use. The load-use case inserts the bubble.

Forwarding is independent of stall and flush; both may be active in the same cycle.

All outputs are combinational with zero-cycle latency and no dependence on CLK or RST_N. Reset does not affect the control outputs.

Optional Feature:
Macro HCU_PERF_CNT_EN.

When defined, the block adds three outputs, each CNT_W wide:
- Stall_Count: increments each CLK rising edge where Stall_En=1.
- Flush_Count: increments each edge where Flush_D=1 (mispredict).
- Fwd_Count: increments each edge where FWD_SrcA!=FWD_NONE or FWD_SrcB!=FWD_NONE.

Counter rules:
- Each counter increments by at most 1 per cycle.
- Counters saturate at all-ones.
- Asserting RST_N=0 clears all counters to 0 immediately, including mid-count.

When the macro is undefined:
- The counters and their ports do not exist.
- CLK and RST_N are present but unused.

Test Plan:
- No hazard: RS1_E=0, RS2_E=1, RD_M=3, RD_W=2, both write enables 0, Result_Src_Sel_E=RESULT_ALU, branch=predict=0 -> FWD_NONE/FWD_NONE, Stall_En=0, Flush_D=0, Flush_E=0, PC_En=1.
- Index matches with write enables 0, and a load with no dependence (RD_E=31, RS1_D=3, RS2_D=1) -> all outputs idle, PC_En=1.
- RS1_E=1, RD_M=1, REG_W_En_M=1 -> FWD_SrcA=FWD_MEM. RS2_E=3, RD_W=3, REG_W_En_W=1 -> FWD_SrcB=FWD_WB. RD_M=RD_W=RS1_E=5 with both enables 1 -> FWD_MEM. RS1_E=0=RD_M with REG_W_En_M=1 -> FWD_NONE.
- Mispredict: Branch_Taken_E=1, Predict_Taken_E=0, and the reverse -> Flush_D=1, Flush_E=1, Stall_En=0, PC_En=1.
- Load-use: Result_Src_Sel_E=RESULT_MEM, RD_E=5, RS2_D=5 -> Stall_En=1, PC_En=0, Flush_E=1, Flush_D=0. Same with RD_E=0 -> no stall. Load-use plus mispredict -> Stall_En=0, Flush_D=1, Flush_E=1, PC_En=1.
- With HCU_PERF_CNT_EN: 3 stall cycles then 2 mispredict cycles -> Stall_Count=3, Flush_Count=2. Pulse RST_N low -> all counters read 0 without waiting for a clock edge.

Source files
------------

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller for the five-stage RV32I pipeline: forwarding selects, load-use stall and mispredict flush.
// Define HCU_PERF_CNT_EN to add saturating stall/flush/forward performance counters.

package hazard_ctrl_pkg;
   localparam logic [1:0] FWD_NONE   = 2'b00;
   localparam logic [1:0] FWD_WB     = 2'b01;
   localparam logic [1:0] FWD_MEM    = 2'b10;
   localparam logic [1:0] RESULT_ALU = 2'h0;
   localparam logic [1:0] RESULT_MEM = 2'h1;
endpackage

module hazard_ctrl_unit
   import hazard_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [4:0]       RS1_D,
   input  logic [4:0]       RS2_D,
   input  logic [4:0]       RD_E,
   input  logic [1:0]       Result_Src_Sel_E,
   input  logic [4:0]       RS1_E,
   input  logic [4:0]       RS2_E,
   input  logic [4:0]       RD_M,
   input  logic [4:0]       RD_W,
   input  logic             REG_W_En_M,
   input  logic             REG_W_En_W,
   input  logic             Branch_Taken_E,
   input  logic             Predict_Taken_E,
   output logic [1:0]       FWD_SrcA,
   output logic [1:0]       FWD_SrcB,
   output logic             Stall_En,
   output logic             Flush_D,
   output logic             Flush_E,
`ifdef HCU_PERF_CNT_EN
   output logic             PC_En,
   output logic [CNT_W-1:0] Stall_Count,
   output logic [CNT_W-1:0] Flush_Count,
   output logic [CNT_W-1:0] Fwd_Count
`else
   output logic             PC_En
`endif
);

   logic load_use;
   logic mispredict;

   // Memory stage wins over Writeback because it carries the younger value; x0 is never forwarded.
   function automatic logic [1:0] fwd_select(input logic [4:0] rs);
      logic [1:0] sel;
      sel = FWD_NONE;
      if (rs != 5'd0) begin
         if (REG_W_En_M && (RD_M == rs)) begin
            sel = FWD_MEM;
         end else if (REG_W_En_W && (RD_W == rs)) begin
            sel = FWD_WB;
         end
      end
      return sel;
   endfunction

   always_comb begin
      FWD_SrcA = fwd_select(RS1_E);
      FWD_SrcB = fwd_select(RS2_E);
   end

   always_comb begin
      load_use   = (Result_Src_Sel_E == RESULT_MEM) && (RD_E != 5'd0) &&
                   ((RD_E == RS1_D) || (RD_E == RS2_D));
      mispredict = (Branch_Taken_E != Predict_Taken_E);
   end

   // A mispredict makes the Decode instruction wrong-path, so it is flushed rather than stalled.
   always_comb begin
      Stall_En = load_use && !mispredict;
      PC_En    = !Stall_En;
      Flush_D  = mispredict;
      Flush_E  = mispredict || load_use;
   end

`ifdef HCU_PERF_CNT_EN
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic fwd_active;

   always_comb begin
      fwd_active = (FWD_SrcA != FWD_NONE) || (FWD_SrcB != FWD_NONE);
   end

   // Counters stick at all-ones instead of wrapping.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         Stall_Count <= '0;
         Flush_Count <= '0;
         Fwd_Count   <= '0;
      end else begin
         if (Stall_En && (Stall_Count != '1)) begin
            Stall_Count <= Stall_Count + CNT_ONE;
         end
         if (Flush_D && (Flush_Count != '1)) begin
            Flush_Count <= Flush_Count + CNT_ONE;
         end
         if (fwd_active && (Fwd_Count != '1)) begin
            Fwd_Count <= Fwd_Count + CNT_ONE;
         end
      end
   end
`else
   logic unused_sigs;
   assign unused_sigs = &{1'b0, CLK, RST_N, (CNT_W > 0)};
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Randomized self-checking bench for hazard_ctrl_unit against a rule-level reference model.
// Counter checks are compiled in when HCU_PERF_CNT_EN is defined.

module tb_hazard_ctrl_unit;

   localparam int CNT_W = 32;

   logic             CLK;
   logic             RST_N;
   logic [4:0]       RS1_D, RS2_D, RD_E, RS1_E, RS2_E, RD_M, RD_W;
   logic [1:0]       Result_Src_Sel_E;
   logic             REG_W_En_M, REG_W_En_W, Branch_Taken_E, Predict_Taken_E;
   logic [1:0]       FWD_SrcA, FWD_SrcB;
   logic             Stall_En, Flush_D, Flush_E, PC_En;
`ifdef HCU_PERF_CNT_EN
   logic [CNT_W-1:0] Stall_Count, Flush_Count, Fwd_Count;
`endif

   logic [CNT_W-1:0] modelStall, modelFlush, modelFwd;
   int               assertCount = 0;
   int               failCount   = 0;

   hazard_ctrl_unit #(.CNT_W(CNT_W)) dut (
      .CLK(CLK),
      .RST_N(RST_N),
      .RS1_D(RS1_D),
      .RS2_D(RS2_D),
      .RD_E(RD_E),
      .Result_Src_Sel_E(Result_Src_Sel_E),
      .RS1_E(RS1_E),
      .RS2_E(RS2_E),
      .RD_M(RD_M),
      .RD_W(RD_W),
      .REG_W_En_M(REG_W_En_M),
      .REG_W_En_W(REG_W_En_W),
      .Branch_Taken_E(Branch_Taken_E),
      .Predict_Taken_E(Predict_Taken_E),
      .FWD_SrcA(FWD_SrcA),
      .FWD_SrcB(FWD_SrcB),
      .Stall_En(Stall_En),
      .Flush_D(Flush_D),
      .Flush_E(Flush_E),
`ifdef HCU_PERF_CNT_EN
      .PC_En(PC_En),
      .Stall_Count(Stall_Count),
      .Flush_Count(Flush_Count),
      .Fwd_Count(Fwd_Count)
`else
      .PC_En(PC_En)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   function automatic logic [1:0] modelFwdSel(input logic [4:0] rs);
      if (rs == 5'd0) return 2'b00;
      if (REG_W_En_M && RD_M == rs) return 2'b10;
      if (REG_W_En_W && RD_W == rs) return 2'b01;
      return 2'b00;
   endfunction

   task automatic applyStimulus(input logic [4:0] rs1d, input logic [4:0] rs2d, input logic [4:0] rde,
                                input logic [1:0] rsrc, input logic [4:0] rs1e, input logic [4:0] rs2e,
                                input logic [4:0] rdm, input logic [4:0] rdw, input logic enm,
                                input logic enw, input logic bt, input logic pt);
      RS1_D = rs1d; RS2_D = rs2d; RD_E = rde; Result_Src_Sel_E = rsrc;
      RS1_E = rs1e; RS2_E = rs2e; RD_M = rdm; RD_W = rdw;
      REG_W_En_M = enm; REG_W_En_W = enw; Branch_Taken_E = bt; Predict_Taken_E = pt;
   endtask

   task automatic checkCounters(input string tag);
`ifdef HCU_PERF_CNT_EN
      checkOutput({tag, ".stall_cnt"}, Stall_Count, modelStall);
      checkOutput({tag, ".flush_cnt"}, Flush_Count, modelFlush);
      checkOutput({tag, ".fwd_cnt"}, Fwd_Count, modelFwd);
`else
      if (tag.len() < 0) $display("[TB] %s", tag);
`endif
   endtask

   // One cycle: verify counters from earlier cycles, drive inputs, check combinational outputs,
   // then account for what the next rising edge should add.
   task automatic runVector(input string tag, input logic [4:0] rs1d, input logic [4:0] rs2d,
                            input logic [4:0] rde, input logic [1:0] rsrc, input logic [4:0] rs1e,
                            input logic [4:0] rs2e, input logic [4:0] rdm, input logic [4:0] rdw,
                            input logic enm, input logic enw, input logic bt, input logic pt);
      logic       loadUse, mis, stall;
      logic [1:0] expA, expB;
      @(negedge CLK);
      checkCounters(tag);
      applyStimulus(rs1d, rs2d, rde, rsrc, rs1e, rs2e, rdm, rdw, enm, enw, bt, pt);
      #1;
      expA    = modelFwdSel(rs1e);
      expB    = modelFwdSel(rs2e);
      loadUse = (rsrc == 2'd1) && (rde != 5'd0) && ((rde == rs1d) || (rde == rs2d));
      mis     = (bt != pt);
      stall   = loadUse && !mis;
      checkOutput({tag, ".fwdA"}, 32'(FWD_SrcA), 32'(expA));
      checkOutput({tag, ".fwdB"}, 32'(FWD_SrcB), 32'(expB));
      checkOutput({tag, ".stall"}, 32'(Stall_En), 32'(stall));
      checkOutput({tag, ".pc_en"}, 32'(PC_En), 32'(!stall));
      checkOutput({tag, ".flushD"}, 32'(Flush_D), 32'(mis));
      checkOutput({tag, ".flushE"}, 32'(Flush_E), 32'(mis || loadUse));
      if (stall && modelStall != '1) modelStall++;
      if (mis && modelFlush != '1) modelFlush++;
      if ((expA != 2'b00 || expB != 2'b00) && modelFwd != '1) modelFwd++;
   endtask

   // Reset is asserted and checked between edges, so clearing must not wait for a clock.
   task automatic pulseReset(input string tag);
      @(negedge CLK);
      #1;
      RST_N = 1'b0;
      applyStimulus(5'd0, 5'd0, 5'd0, 2'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      modelStall = '0;
      modelFlush = '0;
      modelFwd   = '0;
      #1;
      checkCounters(tag);
      checkOutput({tag, ".pc_en"}, 32'(PC_En), 32'd1);
      RST_N = 1'b1;
   endtask

   function automatic logic [4:0] randIdx();
      if ($urandom_range(0, 3) == 0) return 5'($urandom);
      return 5'($urandom_range(0, 3));
   endfunction

   initial begin
      RST_N      = 1'b0;
      modelStall = '0;
      modelFlush = '0;
      modelFwd   = '0;
      applyStimulus(5'd0, 5'd0, 5'd0, 2'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (2) @(posedge CLK);
      #1;
      checkCounters("reset");
      RST_N = 1'b1;

      runVector("no_hazard",   5'd0, 5'd0, 5'd0, 2'd0, 5'd0, 5'd1, 5'd3, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0);
      runVector("match_no_we", 5'd3, 5'd1, 5'd31, 2'd1, 5'd3, 5'd2, 5'd3, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0);
      runVector("fwd_mem_a",   5'd0, 5'd0, 5'd0, 2'd0, 5'd1, 5'd0, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      runVector("fwd_wb_b",    5'd0, 5'd0, 5'd0, 2'd0, 5'd0, 5'd3, 5'd0, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0);
      runVector("fwd_prio",    5'd0, 5'd0, 5'd0, 2'd0, 5'd5, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
      runVector("fwd_x0",      5'd0, 5'd0, 5'd0, 2'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      runVector("mispred_tn",  5'd0, 5'd0, 5'd0, 2'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      runVector("mispred_nt",  5'd0, 5'd0, 5'd0, 2'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      runVector("load_use",    5'd0, 5'd5, 5'd5, 2'd1, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      runVector("load_x0",     5'd0, 5'd0, 5'd0, 2'd1, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      runVector("load_mispr",  5'd5, 5'd0, 5'd5, 2'd1, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      runVector("alu_nostall", 5'd5, 5'd5, 5'd5, 2'd2, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);

      pulseReset("rst_a");
      for (int i = 0; i < 3; i++)
         runVector("cnt_stall", 5'd7, 5'd0, 5'd7, 2'd1, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++)
         runVector("cnt_flush", 5'd0, 5'd0, 5'd0, 2'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      runVector("cnt_idle",  5'd0, 5'd0, 5'd0, 2'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef HCU_PERF_CNT_EN
      checkOutput("cnt_plan.stall", Stall_Count, 32'd3);
      checkOutput("cnt_plan.flush", Flush_Count, 32'd2);
      checkOutput("cnt_plan.fwd", Fwd_Count, 32'd0);
`endif

      for (int i = 0; i < 400; i++) begin
         runVector("rand", randIdx(), randIdx(), randIdx(), 2'($urandom_range(0, 3)), randIdx(), randIdx(),
                   randIdx(), randIdx(), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
         if (i == 200) pulseReset("rst_mid");
      end
      runVector("final", 5'd0, 5'd0, 5'd0, 2'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      pulseReset("rst_end");

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
